// File: rtl/spmp_seq_checker.sv
// Sequential SPMP checker: scans LANES entries per cycle, lowest matching index wins.
// Optional one-entry last-result cache enabled by defining SPMP_LAST_HIT_EN.
package config_pkg;
  typedef struct packed {
    int unsigned PLEN;
  } cva6_cfg_t;
  localparam cva6_cfg_t cva6_cfg_empty = '{PLEN: 32'd34};
endpackage

package riscv;
  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;
endpackage

module spmp_seq_checker #(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int unsigned NR_ENTRIES = 16,
  parameter int unsigned LANES = 4,
  localparam int unsigned PLEN = CVA6Cfg.PLEN,
  localparam int unsigned IW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [PLEN-1:0]       req_addr_i,
  input  logic [PLEN-3:0]       spmpaddr_i [NR_ENTRIES],
  input  riscv::pmp_addr_mode_t spmpmode_i [NR_ENTRIES],
  input  logic [2:0]            spmpperm_i [NR_ENTRIES],
  input  logic                  flush_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_match_o,
  output logic [IW-1:0]         rsp_idx_o,
  output logic [2:0]            rsp_perm_o
);

  localparam int unsigned BW = $clog2(NR_ENTRIES + LANES + 1);

  typedef enum logic [1:0] {IDLE = 2'b00, SCAN = 2'b01, RESP = 2'b10} state_e;

  state_e          state_q;
  logic [BW-1:0]   base_q;
  logic [PLEN-1:0] addr_q;
  logic            match_q;
  logic [IW-1:0]   idx_q;
  logic [2:0]      perm_q;

  logic            hit_s;
  logic [IW-1:0]   hit_idx_s;
  logic [2:0]      hit_perm_s;
  logic            last_s;

`ifdef SPMP_LAST_HIT_EN
  logic            cache_vld_q;
  logic [PLEN-3:0] cache_tag_q;
  logic            cache_match_q;
  logic [IW-1:0]   cache_idx_q;
  logic [2:0]      cache_perm_q;
`endif

  // Region test for one entry; TOR with prev >= cur can never satisfy prev <= a < cur.
  function automatic logic entry_match(input logic [IW-1:0] e, input logic [PLEN-1:0] a);
    logic [PLEN-1:0] cur;
    logic [PLEN-1:0] prev;
    logic [PLEN-1:0] mask;
    int ones;
    cur  = {spmpaddr_i[e], 2'b00};
    prev = (e == '0) ? '0 : {spmpaddr_i[e - IW'(1)], 2'b00};
    ones = 0;
    for (int b = 0; b < int'(PLEN) - 2; b++) begin
      if (spmpaddr_i[e][b] && ones == b) ones = ones + 1;
    end
    mask = {PLEN{1'b1}} << (ones + 3);
    case (spmpmode_i[e])
      riscv::OFF:   entry_match = 1'b0;
      riscv::TOR:   entry_match = (a >= prev) && (a < cur);
      riscv::NA4:   entry_match = (a[PLEN-1:2] == spmpaddr_i[e]);
      riscv::NAPOT: entry_match = ((a & mask) == (cur & mask));
      default:      entry_match = 1'b0;
    endcase
  endfunction

  // Chunk evaluation; descending loop leaves the lowest matching lane in hit_idx_s.
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    hit_perm_s = 3'b000;
    for (int l = int'(LANES) - 1; l >= 0; l--) begin
      if ((int'(base_q) + l < int'(NR_ENTRIES)) && entry_match(IW'(int'(base_q) + l), addr_q)) begin
        hit_s     = 1'b1;
        hit_idx_s = IW'(int'(base_q) + l);
      end
    end
    if (hit_s) begin
      hit_perm_s = spmpperm_i[hit_idx_s];
    end else begin
      hit_perm_s = 3'b000;
    end
    last_s = (int'(base_q) + int'(LANES) >= int'(NR_ENTRIES));
  end

  // Control FSM with latched result registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      addr_q  <= '0;
      match_q <= 1'b0;
      idx_q   <= '0;
      perm_q  <= 3'b000;
`ifdef SPMP_LAST_HIT_EN
      cache_vld_q   <= 1'b0;
      cache_tag_q   <= '0;
      cache_match_q <= 1'b0;
      cache_idx_q   <= '0;
      cache_perm_q  <= 3'b000;
`endif
    end else if (flush_i) begin
      state_q <= IDLE;
      base_q  <= '0;
`ifdef SPMP_LAST_HIT_EN
      cache_vld_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q <= req_addr_i;
            base_q <= '0;
`ifdef SPMP_LAST_HIT_EN
            if (cache_vld_q && (cache_tag_q == req_addr_i[PLEN-1:2])) begin
              match_q <= cache_match_q;
              idx_q   <= cache_idx_q;
              perm_q  <= cache_perm_q;
              state_q <= RESP;
            end else begin
              state_q <= SCAN;
            end
`else
            state_q <= SCAN;
`endif
          end
        end
        SCAN: begin
          if (hit_s || last_s) begin
            match_q <= hit_s;
            idx_q   <= hit_idx_s;
            perm_q  <= hit_perm_s;
            state_q <= RESP;
`ifdef SPMP_LAST_HIT_EN
            cache_vld_q   <= 1'b1;
            cache_tag_q   <= addr_q[PLEN-1:2];
            cache_match_q <= hit_s;
            cache_idx_q   <= hit_idx_s;
            cache_perm_q  <= hit_perm_s;
`endif
          end else begin
            base_q <= base_q + BW'(LANES);
          end
        end
        RESP: begin
          if (rsp_ready_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_match_o = match_q;
  assign rsp_idx_o   = idx_q;
  assign rsp_perm_o  = perm_q;

endmodule

// File: tb/tb_spmp_seq_checker.sv
// Randomized self-checking bench for spmp_seq_checker against an entry-by-entry
// reference model; expected cache behaviour follows SPMP_LAST_HIT_EN.
module tb_spmp_seq_checker;
  localparam int NR = 16;
  localparam int L  = 4;
  localparam int PLEN = 34;

  logic                  clk_i = 1'b0;
  logic                  rst_i = 1'b1;
  logic                  req_valid_i = 1'b0;
  logic                  req_ready_o;
  logic [PLEN-1:0]       req_addr_i = '0;
  logic [PLEN-3:0]       cfg_addr [NR];
  riscv::pmp_addr_mode_t cfg_mode [NR];
  logic [2:0]            cfg_perm [NR];
  logic                  flush_i = 1'b0;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i = 1'b0;
  logic                  rsp_match_o;
  logic [3:0]            rsp_idx_o;
  logic [2:0]            rsp_perm_o;

  int n_cmp = 0;
  int n_err = 0;

  bit          c_vld = 0;
  longint      c_tag;
  bit          c_m;
  int          c_idx, c_perm;

  spmp_seq_checker #(.NR_ENTRIES(NR), .LANES(L)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_addr_i(req_addr_i),
    .spmpaddr_i(cfg_addr), .spmpmode_i(cfg_mode), .spmpperm_i(cfg_perm),
    .flush_i(flush_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_match_o(rsp_match_o),
    .rsp_idx_o(rsp_idx_o), .rsp_perm_o(rsp_perm_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Reference: walk entries in priority order using plain arithmetic on addresses.
  function automatic void model(input longint a, output bit m, output int idx,
                                output int perm, output int lat);
    longint cur, prev;
    int t;
    bit ok;
    m = 0; idx = 0; perm = 0;
    lat = (NR + L - 1) / L + 1;
    for (int i = 0; i < NR; i++) begin
      cur = longint'(cfg_addr[i]);
      ok = 0;
      case (cfg_mode[i])
        riscv::TOR: begin
          prev = (i == 0) ? 64'sd0 : longint'(cfg_addr[i-1]);
          ok = (a >= prev * 4) && (a < cur * 4);
        end
        riscv::NA4: ok = (a / 4 == cur);
        riscv::NAPOT: begin
          t = 0;
          while (t < PLEN - 2 && cur[t]) t++;
          if (t >= PLEN - 2) ok = 1;
          else ok = ((a >> (t + 3)) == ((cur * 4) >> (t + 3)));
        end
        default: ok = 0;
      endcase
      if (ok) begin
        m = 1; idx = i; perm = int'(cfg_perm[i]); lat = i / L + 2;
        break;
      end
    end
  endfunction

  task automatic clear_cfg();
    for (int i = 0; i < NR; i++) begin
      cfg_addr[i] = '0;
      cfg_mode[i] = riscv::OFF;
      cfg_perm[i] = 3'b000;
    end
  endtask

  task automatic do_flush();
    flush_i = 1'b1;
    step();
    flush_i = 1'b0;
    c_vld = 0;
  endtask

  // One request: accept, measure latency, check fields, hold RESP for `hold` cycles.
  task automatic do_req(input string tag, input longint a, input int hold);
    bit m; int idx, perm, lat, n;
    longint s_m, s_i, s_p;
    model(a, m, idx, perm, lat);
`ifdef SPMP_LAST_HIT_EN
    if (c_vld && (a >> 2) == c_tag) begin
      m = c_m; idx = c_idx; perm = c_perm; lat = 1;
    end else begin
      c_vld = 1; c_tag = a >> 2; c_m = m; c_idx = idx; c_perm = perm;
    end
`endif
    check_val({tag, ".ready"}, req_ready_o, 1);
    req_addr_i = a[PLEN-1:0];
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    n = 1;
    while (!rsp_valid_o && n < 40) begin
      step();
      n++;
    end
    check_val({tag, ".lat"}, n, lat);
    check_val({tag, ".match"}, rsp_match_o, m);
    check_val({tag, ".idx"}, rsp_idx_o, idx);
    check_val({tag, ".perm"}, rsp_perm_o, perm);
    s_m = rsp_match_o; s_i = rsp_idx_o; s_p = rsp_perm_o;
    for (int h = 0; h < hold; h++) begin
      step();
      check_val({tag, ".hold_vld"}, rsp_valid_o, 1);
      check_val({tag, ".hold_rdy"}, req_ready_o, 0);
      check_val({tag, ".hold_fields"}, {rsp_match_o, rsp_idx_o, rsp_perm_o}, {s_m[0], s_i[3:0], s_p[2:0]});
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    check_val({tag, ".idle"}, {req_ready_o, rsp_valid_o}, 2'b10);
  endtask

  // Accept a non-matching request, then abort it in the 2nd SCAN cycle.
  task automatic abort_scan(input string tag, input bit use_rst);
    bit seen;
    req_addr_i = 34'h0_0000_0100;
    req_valid_i = 1'b1;
    step();
    req_valid_i = 1'b0;
    step();
    if (use_rst) rst_i = 1'b1; else flush_i = 1'b1;
    step();
    rst_i = 1'b0; flush_i = 1'b0;
    c_vld = 0;
    check_val({tag, ".ready"}, req_ready_o, 1);
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid_o) seen = 1;
      step();
    end
    check_val({tag, ".no_rsp"}, seen, 0);
  endtask

  initial begin
    longint a, last_a;
    bit seen;
    clear_cfg();
    step();
    step();
    check_val("rst.ready", req_ready_o, 1);
    check_val("rst.valid", rsp_valid_o, 0);
    check_val("rst.fields", {rsp_match_o, rsp_idx_o, rsp_perm_o}, 0);
    rst_i = 1'b0;
    step();

    // NAPOT entry in chunk 1; repeat exercises the cache when enabled.
    cfg_addr[5] = 32'h0040_01FF; cfg_mode[5] = riscv::NAPOT; cfg_perm[5] = 3'b011;
    do_flush();
    do_req("napot", 64'h100_0ABC, 3);
    do_req("napot2", 64'h100_0ABC, 0);
    do_flush();
    do_req("napot3", 64'h100_0ABC, 0);

    clear_cfg();
    cfg_addr[1] = 32'h400;
    cfg_addr[2] = 32'h800; cfg_mode[2] = riscv::TOR; cfg_perm[2] = 3'b101;
    do_flush();
    do_req("tor_in", 64'h1FFC, 1);
    do_req("tor_out", 64'h2000, 0);
    do_req("tor_lo", 64'h1000, 0);

    clear_cfg();
    cfg_addr[3] = '1; cfg_mode[3] = riscv::NAPOT; cfg_perm[3] = 3'b001;
    cfg_addr[9] = '1; cfg_mode[9] = riscv::NAPOT; cfg_perm[9] = 3'b110;
    do_flush();
    do_req("prio", 64'h0, 0);

    clear_cfg();
    do_flush();
    abort_scan("flush_mid", 1'b0);
    abort_scan("rst_mid", 1'b1);

    // Flush while idle blocks acceptance.
    flush_i = 1'b1; req_valid_i = 1'b1; req_addr_i = 34'h40;
    step();
    flush_i = 1'b0; req_valid_i = 1'b0;
    c_vld = 0;
    seen = 0;
    for (int k = 0; k < 7; k++) begin
      if (!req_ready_o || rsp_valid_o) seen = 1;
      step();
    end
    check_val("idle_flush", seen, 0);

    last_a = 0;
    for (int it = 0; it < 60; it++) begin
      if (it % 6 == 0) begin
        for (int i = 0; i < NR; i++) begin
          cfg_mode[i] = riscv::pmp_addr_mode_t'($urandom_range(0, 3));
          cfg_perm[i] = 3'($urandom_range(0, 7));
          cfg_addr[i] = 32'($urandom_range(0, 32'h3FFF));
          if ($urandom_range(0, 20) == 0) cfg_addr[i] = '1;
        end
        do_flush();
      end
      if ($urandom_range(0, 3) == 0) a = last_a;
      else a = longint'($urandom_range(0, 32'h1_FFFF));
      last_a = a;
      do_req("rand", a, $urandom_range(0, 2));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
